memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline; sits between execute and writeback.
//  - Consumes execute_to_memory_t. Issues loads/stores on a req/gnt/rvalid data-memory bus.
//  - Produces memory_to_writeback_t. For loads, alu_result is replaced by the formatted load data.
//  - Non-memory instructions pass through with a one-cycle registered latency.
// PARAMETERS
//  ADDR_WIDTH  32  data-memory address width (= common::MEM_ADDRESS_WIDTH)
//  DATA_WIDTH  32  data bus width; only 32 is supported (= REGISTER_WIDTH)
// PORTS
//  clk             in   1     clock; all logic on rising edge
//  rst_n           in   1     synchronous reset, active-low
//  in_valid        in   1     execute result valid
//  in_ready        out  1     stage can accept in_data this cycle
//  in_data         in   $bits(execute_to_memory_t)   from execute
//  out_valid       out  1     out_data valid
//  out_ready       in   1     writeback accepts out_data
//  out_data        out  $bits(memory_to_writeback_t) to writeback
//  out_misaligned  out  1     misaligned access flag, qualified by out_valid
//  mem_req         out  1     data-memory request
//  mem_we          out  1     1 = store, 0 = load
//  mem_addr        out  ADDR_WIDTH  word-aligned address {alu_result[31:2],2'b00}
//  mem_wdata       out  DATA_WIDTH  store data, lane-replicated
//  mem_be          out  4     byte enables
//  mem_gnt         in   1     request accepted this cycle
//  mem_rvalid      in   1     load data valid
//  mem_rdata       in   DATA_WIDTH  load data (whole word)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; out_valid, mem_req, mem_we, out_misaligned = 0;
//    mem_be = 0; out_data, mem_addr, mem_wdata = 0. A reset mid-transaction abandons it; later mem_rvalid is ignored.
//  - FSM IDLE -> ISSUE -> (WAIT_RSP) -> IDLE.
//    IDLE: in_ready = !out_valid | out_ready; the accept condition is in_valid & in_ready.
//      - Opcode not LOAD/STORE: out_data is registered and out_valid=1 next cycle. The stage stays IDLE, so back-to-back throughput is 1/cycle.
//      - LOAD/STORE: latch the instruction, go to ISSUE. mem_req=1 from the next cycle.
//    ISSUE: in_ready=0. mem_req, mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_gnt.
//      - mem_gnt with a store: register out_data, out_valid=1 next cycle, go to IDLE.
//      - mem_gnt with a load: go to WAIT_RSP.
//    WAIT_RSP: in_ready=0, mem_req=0. On mem_rvalid, register the formatted load into out_data.alu_result, out_valid=1, go to IDLE.
//      A mem_rvalid that arrives in the same cycle as mem_gnt is not legal on this bus.
//  - out_valid stays high until out_ready is seen; out_data is held stable meanwhile.
//    The output register is always empty when a memory op completes, because accept requires it drained.
//  - Output field rules:
//    - decoded_instruction and branch_target pass through unchanged.
//    - alu_result passes through for non-load ops.
//  - Store lanes use off = alu_result[1:0]:
//      SB: wdata = {4{rs2[7:0]}},  be = 4'b0001 << off
//      SH: wdata = {2{rs2[15:0]}}, be = 4'b0011 << {off[1],1'b0}
//      SW: wdata = rs2,            be = 4'b1111
//      other funct3: be = 4'b0000; the request is still issued.
//  - Load format:
//      LB/LBU: byte at off, sign- or zero-extended.
//      LH/LHU: half at off[1], sign- or zero-extended.
//      LW: whole word.
//      other funct3: result 0.
// CONFIGURATION
//  Macro MISALIGNED_TRAP_EN.
//  - Defined: an access is misaligned if it is a halfword with off[0]=1, or a word with off!=0.
//    - No mem_req is issued for it.
//    - The output is registered next cycle from IDLE, with out_misaligned=1 and alu_result = the unmodified address.
//  - Undefined: low address bits are truncated as in the lane rules above. out_misaligned is tied to 0.
// STRUCTURE
//  - Add to package common:
//    - mem_stage_state_t enum {IDLE, ISSUE, WAIT_RSP}
//    - localparam BYTE_LANES = REGISTER_WIDTH/BYTE_WIDTH
//    - funct3 typedefs already there are reused: STypeFunct3, FUNC3_LOAD.
//  - Sub-module load_data_align: combinational (rdata, funct3, off) -> RegisterValue, used for the load format.
//  - Store lane generation stays inline in memory_stage.
// TESTING
//  1. ADD passthrough, alu_result=0x1234, out_ready=1 -> out_valid next cycle, alu_result=0x1234, no mem_req.
//  2. SB rs2=0xAABBCCDD, addr=0x103 -> mem_addr=0x100, be=4'b1000, wdata=0xDDDDDDDD.
//     Holding gnt low for 3 cycles keeps the request stable; out_valid comes 1 cycle after gnt.
//  3. LB addr=0x201, rdata=0x0000_8000 -> result 0xFFFFFF80.
//     LBU with the same inputs -> 0x00000080. LH addr=0x202, rdata=0x80010000 -> 0xFFFF8001.
//  4. Load with out_ready=0 for 4 cycles after rvalid -> out_data held, in_ready=0.
//     in_ready rises in the cycle out_ready=1.
//  5. rst_n=0 in WAIT_RSP, then a late rvalid -> out_valid stays 0, state=IDLE, mem_req=0.
//  6. LW addr=0x302: with MISALIGNED_TRAP_EN -> no mem_req, out_misaligned=1, alu_result=0x302.
//     Without it -> mem_addr=0x300, full word returned.

Source files
------------

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared RV32I pipeline types and constants used by the memory stage
package common;

    localparam int REGISTER_WIDTH    = 32;
    localparam int BYTE_WIDTH        = 8;
    localparam int MEM_ADDRESS_WIDTH = 32;
    localparam int BYTE_LANES        = REGISTER_WIDTH / BYTE_WIDTH;

    typedef logic [REGISTER_WIDTH-1:0] RegisterValue;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
    localparam logic [6:0] OPCODE_OP    = 7'b0110011;

    typedef enum logic [2:0] {
        FUNCT3_SB = 3'b000,
        FUNCT3_SH = 3'b001,
        FUNCT3_SW = 3'b010
    } STypeFunct3;

    typedef enum logic [2:0] {
        FUNCT3_LB  = 3'b000,
        FUNCT3_LH  = 3'b001,
        FUNCT3_LW  = 3'b010,
        FUNCT3_LBU = 3'b100,
        FUNCT3_LHU = 3'b101
    } FUNC3_LOAD;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } mem_stage_state_t;

    typedef struct packed {
        logic [6:0]   opcode;
        logic [4:0]   rd;
        logic [2:0]   funct3;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        RegisterValue imm;
    } decoded_instruction_t;

    typedef struct packed {
        decoded_instruction_t decoded_instruction;
        RegisterValue         alu_result;
        RegisterValue         rs2_value;
        RegisterValue         branch_target;
    } execute_to_memory_t;

    typedef struct packed {
        decoded_instruction_t decoded_instruction;
        RegisterValue         alu_result;
        RegisterValue         branch_target;
    } memory_to_writeback_t;

    function automatic memory_to_writeback_t to_writeback(execute_to_memory_t e, RegisterValue result);
        memory_to_writeback_t w;
        w.decoded_instruction = e.decoded_instruction;
        w.alu_result          = result;
        w.branch_target       = e.branch_target;
        return w;
    endfunction

endpackage

// File: rtl/memory_stage_load_data_align.sv
// rtl/memory_stage_load_data_align.sv - extracts and extends a load byte/half/word from a memory word
module load_data_align
    import common::*;
(
    input  RegisterValue rdata,
    input  logic [2:0]   funct3,
    input  logic [1:0]   off,
    output RegisterValue result
);

    logic [BYTE_WIDTH-1:0]   sel_byte;
    logic [2*BYTE_WIDTH-1:0] sel_half;

    always_comb begin
        sel_byte = rdata[{off, 3'b000} +: BYTE_WIDTH];
        sel_half = off[1] ? rdata[31:16] : rdata[15:0];
        result   = '0;
        case (funct3)
            FUNCT3_LB:  result = {{24{sel_byte[7]}}, sel_byte};
            FUNCT3_LBU: result = {24'h0, sel_byte};
            FUNCT3_LH:  result = {{16{sel_half[15]}}, sel_half};
            FUNCT3_LHU: result = {16'h0, sel_half};
            FUNCT3_LW:  result = rdata;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I MEM stage: load/store on a req/gnt/rvalid bus, passthrough otherwise
// Optional build macro MISALIGNED_TRAP_EN flags misaligned half/word accesses instead of issuing them.
module memory_stage
    import common::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH = REGISTER_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  execute_to_memory_t   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output memory_to_writeback_t out_data,
    output logic                 out_misaligned,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    mem_stage_state_t     state, state_n;
    execute_to_memory_t   pending;
    memory_to_writeback_t out_n;
    RegisterValue         load_result;
    logic                 latch, load_out, mis_n, mis_in, is_mem_in, pending_store;
    logic [1:0]           p_off, in_off;
    logic [2:0]           p_f3, in_f3;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [3:0]           lane_be;

    assign in_off        = in_data.alu_result[1:0];
    assign in_f3         = in_data.decoded_instruction.funct3;
    assign is_mem_in     = (in_data.decoded_instruction.opcode == OPCODE_LOAD) ||
                           (in_data.decoded_instruction.opcode == OPCODE_STORE);
    assign p_off         = pending.alu_result[1:0];
    assign p_f3          = pending.decoded_instruction.funct3;
    assign pending_store = (pending.decoded_instruction.opcode == OPCODE_STORE);

`ifdef MISALIGNED_TRAP_EN
    assign mis_in = is_mem_in && (((in_f3[1:0] == 2'b01) && in_off[0]) ||
                                  ((in_f3[1:0] == 2'b10) && (in_off != 2'b00)));
`else
    assign mis_in = 1'b0;
`endif

    // Bus outputs derive from the latched instruction, so they stay stable until mem_gnt.
    always_comb begin
        lane_wdata = pending.rs2_value;
        lane_be    = 4'b0000;
        case (p_f3)
            FUNCT3_SB: begin
                lane_wdata = {4{pending.rs2_value[7:0]}};
                lane_be    = 4'b0001 << p_off;
            end
            FUNCT3_SH: begin
                lane_wdata = {2{pending.rs2_value[15:0]}};
                lane_be    = 4'b0011 << {p_off[1], 1'b0};
            end
            FUNCT3_SW: lane_be = 4'b1111;
            default:   lane_be = 4'b0000;
        endcase
    end

    assign mem_req   = (state == ISSUE);
    assign mem_we    = mem_req && pending_store;
    assign mem_be    = mem_req ? lane_be : 4'b0000;
    assign mem_wdata = lane_wdata;
    assign mem_addr  = {pending.alu_result[ADDR_WIDTH-1:2], 2'b00};

    load_data_align u_align (
        .rdata  (mem_rdata),
        .funct3 (p_f3),
        .off    (p_off),
        .result (load_result)
    );

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        latch    = 1'b0;
        load_out = 1'b0;
        out_n    = out_data;
        mis_n    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready) begin
                    if (is_mem_in && !mis_in) begin
                        latch   = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        load_out = 1'b1;
                        out_n    = to_writeback(in_data, in_data.alu_result);
                        mis_n    = mis_in;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (pending_store) begin
                        load_out = 1'b1;
                        out_n    = to_writeback(pending, pending.alu_result);
                        state_n  = IDLE;
                    end else begin
                        state_n = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid) begin
                    load_out = 1'b1;
                    out_n    = to_writeback(pending, load_result);
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            pending        <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_misaligned <= 1'b0;
        end else begin
            state <= state_n;
            if (latch)
                pending <= in_data;
            if (load_out) begin
                out_valid      <= 1'b1;
                out_data       <= out_n;
                out_misaligned <= mis_n;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage with directed load/store/passthrough vectors
module tb_memory_stage;
    import common::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    execute_to_memory_t   in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    memory_to_writeback_t out_data;
    logic                 out_misaligned;
    logic                 mem_req, mem_we;
    logic [31:0]          mem_addr, mem_wdata;
    logic [3:0]           mem_be;
    logic                 mem_gnt = 1'b0;
    logic                 mem_rvalid = 1'b0;
    logic [31:0]          mem_rdata = '0;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] bt;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycles = 0;

    memory_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_misaligned(out_misaligned), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic execute_to_memory_t mk(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                                              logic [31:0] alu, logic [31:0] rs2);
        execute_to_memory_t e;
        e = '0;
        e.decoded_instruction.opcode = op;
        e.decoded_instruction.funct3 = f3;
        e.decoded_instruction.rd     = rd;
        e.alu_result                 = alu;
        e.rs2_value                  = rs2;
        e.branch_target              = alu + 32'h1000;
        return e;
    endfunction

    function automatic void expect_out(logic [31:0] alu, logic [4:0] rd, logic [31:0] src_alu, logic mis);
        exp_t e;
        e.alu = alu; e.rd = rd; e.bt = src_alu + 32'h1000; e.mis = mis;
        q.push_back(e);
    endfunction

    // Monitor: every handshake on the output side pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", out_data.alu_result, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_alu_result", out_data.alu_result, e.alu);
                chk("out_rd", 32'(out_data.decoded_instruction.rd), 32'(e.rd));
                chk("out_branch_target", out_data.branch_target, e.bt);
                chk("out_misaligned", 32'(out_misaligned), 32'(e.mis));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic send(input execute_to_memory_t d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_req(string tag, logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wd);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_addr"}, mem_addr, addr);
        if (we) begin
            chk({tag, "_be"}, 32'(mem_be), 32'(be));
            chk({tag, "_wdata"}, mem_wdata, wd);
        end
    endtask

    task automatic serve_store(string tag, logic [31:0] addr, logic [3:0] be, logic [31:0] wd, int gnt_wait);
        check_req(tag, 1'b1, addr, be, wd);
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            check_req({tag, "_hold"}, 1'b1, addr, be, wd);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({tag, "_out_valid_after_gnt"}, 32'(out_valid), 32'd1);
        chk({tag, "_req_dropped"}, 32'(mem_req), 32'd0);
    endtask

    task automatic serve_load(string tag, logic [31:0] addr, int gnt_wait, logic [31:0] rdata);
        check_req(tag, 1'b0, addr, 4'h0, 32'h0);
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            check_req({tag, "_hold"}, 1'b0, addr, 4'h0, 32'h0);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({tag, "_wait_no_req"}, 32'(mem_req), 32'd0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        int c0, n;
        logic [31:0] held;

        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_out_alu", out_data.alu_result, 32'd0);
        chk("rst_out_misaligned", 32'(out_misaligned), 32'd0);
        rst_n = 1'b1;
        tick();

        // Passthrough, then three back-to-back ALU ops at one per cycle
        expect_out(32'h1234, 5'd1, 32'h1234, 1'b0);
        send(mk(OPCODE_OP, 3'b000, 5'd1, 32'h1234, 32'h0));
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_no_req", 32'(mem_req), 32'd0);
        c0 = cycles;
        for (int i = 0; i < 3; i++) begin
            expect_out(32'h5000 + 32'(i), 5'(2 + i), 32'h5000 + 32'(i), 1'b0);
            send(mk(OPCODE_OP, 3'b000, 5'(2 + i), 32'h5000 + 32'(i), 32'h0));
        end
        chk("b2b_cycles", 32'(cycles - c0), 32'd3);
        tick();

        // Stores: SB with gnt held off for 3 cycles, then SH and SW
        expect_out(32'h103, 5'd0, 32'h103, 1'b0);
        send(mk(OPCODE_STORE, FUNCT3_SB, 5'd0, 32'h103, 32'hAABBCCDD));
        serve_store("sb", 32'h100, 4'b1000, 32'hDDDDDDDD, 3);
        expect_out(32'h102, 5'd0, 32'h102, 1'b0);
        send(mk(OPCODE_STORE, FUNCT3_SH, 5'd0, 32'h102, 32'h11223344));
        serve_store("sh", 32'h100, 4'b1100, 32'h33443344, 0);
        expect_out(32'h104, 5'd0, 32'h104, 1'b0);
        send(mk(OPCODE_STORE, FUNCT3_SW, 5'd0, 32'h104, 32'h11223344));
        serve_store("sw", 32'h104, 4'b1111, 32'h11223344, 1);

        // Load formatting
        expect_out(32'hFFFFFF80, 5'd5, 32'h201, 1'b0);
        send(mk(OPCODE_LOAD, FUNCT3_LB, 5'd5, 32'h201, 32'h0));
        serve_load("lb", 32'h200, 0, 32'h0000_8000);
        expect_out(32'h00000080, 5'd6, 32'h201, 1'b0);
        send(mk(OPCODE_LOAD, FUNCT3_LBU, 5'd6, 32'h201, 32'h0));
        serve_load("lbu", 32'h200, 2, 32'h0000_8000);
        expect_out(32'hFFFF8001, 5'd7, 32'h202, 1'b0);
        send(mk(OPCODE_LOAD, FUNCT3_LH, 5'd7, 32'h202, 32'h0));
        serve_load("lh", 32'h200, 0, 32'h8001_0000);
        expect_out(32'h00008001, 5'd8, 32'h202, 1'b0);
        send(mk(OPCODE_LOAD, FUNCT3_LHU, 5'd8, 32'h202, 32'h0));
        serve_load("lhu", 32'h200, 0, 32'h8001_0000);
        expect_out(32'h0, 5'd9, 32'h208, 1'b0);
        send(mk(OPCODE_LOAD, 3'b011, 5'd9, 32'h208, 32'h0));
        serve_load("ld_bad_f3", 32'h208, 0, 32'hFFFF_FFFF);

        // Backpressure after load completion
        expect_out(32'hCAFEF00D, 5'd10, 32'h400, 1'b0);
        send(mk(OPCODE_LOAD, FUNCT3_LW, 5'd10, 32'h400, 32'h0));
        out_ready = 1'b0;
        serve_load("lw_bp", 32'h400, 0, 32'hCAFEF00D);
        held = out_data.alu_result;
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_held", out_data.alu_result, 32'hCAFEF00D);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("bp_held_value", held, 32'hCAFEF00D);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
        tick();

        // Reset while waiting for read data; the late rvalid must be ignored
        send(mk(OPCODE_LOAD, FUNCT3_LW, 5'd11, 32'h500, 32'h0));
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_state", 32'(dut.state), 32'(IDLE));

        // Misaligned word load
`ifdef MISALIGNED_TRAP_EN
        expect_out(32'h302, 5'd12, 32'h302, 1'b1);
        send(mk(OPCODE_LOAD, FUNCT3_LW, 5'd12, 32'h302, 32'h0));
        chk("mis_no_req", 32'(mem_req), 32'd0);
        chk("mis_out_valid", 32'(out_valid), 32'd1);
        chk("mis_flag", 32'(out_misaligned), 32'd1);
`else
        expect_out(32'h12345678, 5'd12, 32'h302, 1'b0);
        send(mk(OPCODE_LOAD, FUNCT3_LW, 5'd12, 32'h302, 32'h0));
        serve_load("lw_unaligned", 32'h300, 0, 32'h12345678);
`endif

        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
